// File: rtl/mine_placer.sv
// Mine-map writer: clears the 256-cell board, then places NUM_MINES distinct mines away from the first click.
// Optional macro SAFE_ZONE_EN widens the exclusion to the clipped 3x3 neighbourhood of the first-click cell.
module mine_placer #(
  parameter int          NUM_MINES = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] safe_addr,
  output logic [7:0] mine_wr_addr,
  output logic       mine_wr_data,
  output logic       mine_wr_en,
  output logic       busy,
  output logic       done,
  output logic [8:0] placed_count
);

`ifdef SAFE_ZONE_EN
  localparam int MAX_MINES = 247;
`else
  localparam int MAX_MINES = 255;
`endif

  localparam logic [8:0]  NUM_MINES_W = NUM_MINES[8:0];
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  generate
    if ((NUM_MINES < 1) || (NUM_MINES > MAX_MINES)) begin : g_bad_num_mines
      $error("mine_placer: NUM_MINES out of legal range");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("mine_placer: LFSR_SEED must be nonzero");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t       state_r;
  logic [15:0]  lfsr_r;
  logic [255:0] shadow_r;
  logic [7:0]   safe_r;
  logic [8:0]   clr_ptr_r;
  logic [8:0]   count_r;
  logic [7:0]   wr_addr_r;
  logic         wr_data_r;
  logic         wr_en_r;
  logic         busy_r;
  logic         done_r;

  logic [15:0]  lfsr_next_s;
  logic [7:0]   cand_s;
  logic [8:0]   count_inc_s;
  logic         reject_s;

`ifdef SAFE_ZONE_EN
  // Coordinates a and b are within one step of each other, without wrapping at the board edge.
  function automatic logic near_1d(input logic [3:0] a, input logic [3:0] b);
    logic hit;
    hit = (a == b);
    if ((b != 4'hF) && (a == (b + 4'd1))) hit = 1'b1;
    if ((b != 4'h0) && (a == (b - 4'd1))) hit = 1'b1;
    return hit;
  endfunction
`endif

  assign cand_s      = lfsr_r[7:0];
  assign count_inc_s = count_r + 9'd1;

  // Galois LFSR next value; the register steps every cycle regardless of state.
  always_comb begin
    lfsr_next_s = {1'b0, lfsr_r[15:1]};
    if (lfsr_r[0]) begin
      lfsr_next_s = {1'b0, lfsr_r[15:1]} ^ LFSR_TAPS;
    end else begin
      lfsr_next_s = {1'b0, lfsr_r[15:1]};
    end
  end

  // Candidate rejection: the first-click cell, already-mined cells, and optionally its neighbours.
  always_comb begin
    reject_s = 1'b0;
    if (cand_s == safe_r) begin
      reject_s = 1'b1;
    end else if (shadow_r[cand_s]) begin
      reject_s = 1'b1;
    end else begin
`ifdef SAFE_ZONE_EN
      reject_s = near_1d(cand_s[3:0], safe_r[3:0]) && near_1d(cand_s[7:4], safe_r[7:4]);
`else
      reject_s = 1'b0;
`endif
    end
  end

  // Generation FSM with registered write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      lfsr_r    <= LFSR_SEED;
      shadow_r  <= 256'd0;
      safe_r    <= 8'h00;
      clr_ptr_r <= 9'd0;
      count_r   <= 9'd0;
      wr_addr_r <= 8'h00;
      wr_data_r <= 1'b0;
      wr_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      lfsr_r <= lfsr_next_s;
      case (state_r)
        ST_IDLE: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          if (start) begin
            safe_r    <= safe_addr;
            shadow_r  <= 256'd0;
            count_r   <= 9'd0;
            clr_ptr_r <= 9'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_CLEAR;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          wr_en_r   <= 1'b1;
          wr_data_r <= 1'b0;
          wr_addr_r <= clr_ptr_r[7:0];
          clr_ptr_r <= clr_ptr_r + 9'd1;
          if (clr_ptr_r == 9'd255) begin
            state_r <= ST_PLACE;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
        ST_PLACE: begin
          if (!reject_s) begin
            wr_en_r          <= 1'b1;
            wr_data_r        <= 1'b1;
            wr_addr_r        <= cand_s;
            shadow_r[cand_s] <= 1'b1;
            count_r          <= count_inc_s;
            // done rides with the last mine write so the pulse lines up with it on the port
            if (count_inc_s == NUM_MINES_W) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_PLACE;
            end
          end else begin
            wr_en_r <= 1'b0;
          end
        end
        ST_DONE: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign mine_wr_addr = wr_addr_r;
  assign mine_wr_data = wr_data_r;
  assign mine_wr_en   = wr_en_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign placed_count = count_r;

endmodule
